// File: rtl/button_seq_pkg.sv
// Shared definitions for the button sequence player.
//   state_t       playback FSM states
//   BTNx_BIT      bit positions inside the {btn3,btn2,btn0} pattern
//   LFSR_SEED     reset value of the contact-bounce LFSR
package button_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned BTN0_BIT = 0;
  localparam int unsigned BTN2_BIT = 1;
  localparam int unsigned BTN3_BIT = 2;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/button_sequence_player_lfsr.sv
// bounce_lfsr: 8-bit Fibonacci LFSR (taps 8,6,5,4) used to generate contact
// chatter. Only instantiated when BUTTON_SEQ_BOUNCE_EN is defined.
//   clk, rst_n  clock, async active-low reset (loads SEED)
//   en_i        advance one step per cycle while high
//   bits_o      low three LFSR bits, used as a per-button chatter mask
module bounce_lfsr
  import button_seq_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic [2:0] bits_o
);

  logic [7:0] lfsr_q, lfsr_d;
  logic       fb;

  always_comb begin
    fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d = en_i ? {lfsr_q[6:0], fb} : lfsr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign bits_o = lfsr_q[2:0];

endmodule

// File: rtl/button_sequence_player.sv
// button_sequence_player: plays a programmed table of 3-bit button patterns
// onto {btn3,btn2,btn0}. Each step is held HOLD_CYCLES, then all buttons are
// released for GAP_CYCLES. Optional contact-bounce injection is enabled with
// the macro BUTTON_SEQ_BOUNCE_EN.
//   cfg_we/cfg_addr/cfg_pattern  step-table write port (IDLE only)
//   num_steps                    steps to play, latched and clamped on start
//   start / abort                begin playback / stop immediately
//   btn_out                      registered button levels
//   busy / done                  playing / one-cycle completion pulse
//   step_idx                     step currently held or gapped
module button_sequence_player
  import button_seq_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned GAP_CYCLES    = 8,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned BOUNCE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [2:0]                 cfg_pattern,
  input  logic [$clog2(DEPTH):0]     num_steps,
  input  logic                       start,
  input  logic                       abort,
  output logic [2:0]                 btn_out,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   step_idx
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned STEPS_W = IDX_W + 1;

  localparam logic [CNT_W-1:0]   HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_RELOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   BNC_LEN     = CNT_W'(BOUNCE_CYCLES);
  localparam logic [STEPS_W-1:0] DEPTH_S     = STEPS_W'(DEPTH);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [STEPS_W-1:0]   steps_q, steps_d;
  logic [STEPS_W-1:0]   steps_clamped;
  logic                 last_step;

  logic [2:0]           btn_q, btn_d;
  logic                 busy_q, done_q;

  logic [2:0]           table_q [DEPTH];

  logic [2:0]           raw_chatter;
  logic [2:0]           chatter;
  logic                 hold_win, gap_win;
  logic [2:0]           pat_d;

  // ---------------------------------------------------------------------------
  // Chatter source
  // ---------------------------------------------------------------------------
`ifdef BUTTON_SEQ_BOUNCE_EN
  localparam bit BOUNCE_ON = 1'b1;

  bounce_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (1'b1),
    .bits_o (raw_chatter)
  );
`else
  localparam bit BOUNCE_ON = 1'b0;

  assign raw_chatter = '1;
`endif

  assign chatter[BTN0_BIT] = raw_chatter[0];
  assign chatter[BTN2_BIT] = raw_chatter[1];
  assign chatter[BTN3_BIT] = raw_chatter[2];

  // ---------------------------------------------------------------------------
  // Step table (not reset; writable only while idle)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == IDLE)) table_q[cfg_addr] <= cfg_pattern;
  end

  // ---------------------------------------------------------------------------
  // Playback FSM
  // ---------------------------------------------------------------------------
  assign steps_clamped = (num_steps > DEPTH_S) ? DEPTH_S : num_steps;
  assign last_step     = ({1'b0, idx_q} == (steps_q - STEPS_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      steps_q <= steps_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    steps_d = steps_q;

    unique case (state_q)
      IDLE: begin
        // abort outranks a simultaneous start
        if (start && !abort) begin
          steps_d = steps_clamped;
          idx_d   = '0;
          if (steps_clamped == '0) begin
            state_d = DONE;
            timer_d = '0;
          end else begin
            state_d = HOLD;
            timer_d = HOLD_RELOAD;
          end
        end
      end

      HOLD: begin
        if (abort) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == '0) begin
          state_d = GAP;
          timer_d = GAP_RELOAD;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end

      GAP: begin
        if (abort) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == '0) begin
          if (last_step) begin
            state_d = DONE;
            timer_d = '0;
          end else begin
            state_d = HOLD;
            timer_d = HOLD_RELOAD;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        timer_d = '0;
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, computed from the next state so they line up with it.
  // Elapsed time in a phase is reload - timer; the bounce window covers the
  // first BOUNCE_CYCLES cycles of each HOLD and GAP.
  // ---------------------------------------------------------------------------
  always_comb begin
    pat_d    = table_q[idx_d];
    hold_win = BOUNCE_ON && ((HOLD_RELOAD - timer_d) < BNC_LEN);
    gap_win  = BOUNCE_ON && ((GAP_RELOAD  - timer_d) < BNC_LEN);
    btn_d    = '0;

    unique case (state_d)
      HOLD:    btn_d = hold_win ? (pat_d & chatter) : pat_d;
      GAP:     btn_d = gap_win  ? (pat_d & chatter) : '0;
      default: btn_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      btn_q  <= btn_d;
      busy_q <= (state_d == HOLD) || (state_d == GAP);
      done_q <= (state_d == DONE);
    end
  end

  assign btn_out  = btn_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = idx_q;

endmodule

// File: tb/tb_button_sequence_player.sv
// Directed bench for button_sequence_player with HOLD=4, GAP=2, DEPTH=8.
// Build with BUTTON_SEQ_BOUNCE_EN defined to also exercise bounce injection.
module tb_button_sequence_player;

  localparam int DEPTH = 8;
  localparam int H     = 4;
  localparam int G     = 2;
  localparam int P     = H + G;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [2:0] cfg_pattern;
  logic [3:0] num_steps;
  logic       start;
  logic       abort;
  logic [2:0] btn_out;
  logic       busy;
  logic       done;
  logic [2:0] step_idx;

  int checks = 0;
  int errors = 0;

  logic [2:0] tbl_m [DEPTH];

  always #5 clk = ~clk;

  button_sequence_player #(
    .DEPTH         (DEPTH),
    .HOLD_CYCLES   (H),
    .GAP_CYCLES    (G),
    .CNT_W         (16),
    .BOUNCE_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_pattern (cfg_pattern),
    .num_steps   (num_steps),
    .start       (start),
    .abort       (abort),
    .btn_out     (btn_out),
    .busy        (busy),
    .done        (done),
    .step_idx    (step_idx)
  );

`ifdef BUTTON_SEQ_BOUNCE_EN
  localparam int BNC = 2;
  logic [7:0] lfsr_m, lfsr_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_m    <= 8'hA5;
      lfsr_prev <= 8'hA5;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
  end
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected button level for a HOLD (is_hold) or GAP cycle of a step with
  // pattern pat, e cycles into the phase.
  task automatic check_btn(input string tag, input logic [2:0] pat, input bit is_hold, input int e);
    logic [2:0] exp;
    exp = is_hold ? pat : 3'b000;
`ifdef BUTTON_SEQ_BOUNCE_EN
    if (e < BNC) exp = pat & lfsr_prev[2:0];
    check_eq({tag, "_nospur"}, btn_out & ~pat, 0);
`endif
    check_eq(tag, btn_out, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [2:0] p);
    cfg_we      = 1'b1;
    cfg_addr    = 3'(a);
    cfg_pattern = p;
    tick();
    cfg_we      = 1'b0;
    tbl_m[a]    = p;
  endtask

  // Start a run requesting n_req steps; n_exp is the hand-clamped step count.
  // inject: pulse start and a table write at cycle 3 (both must be ignored).
  // abort_at: raise abort during that cycle (0 = never).
  task automatic run_seq(input int n_req, input int n_exp, input bit inject, input int abort_at);
    int total;
    int st;
    int ph;
    num_steps = 4'(n_req);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    total     = n_exp * P;
    for (int c = 1; c <= total + 2; c++) begin
      if (abort_at != 0 && c == abort_at + 1) begin
        abort = 1'b0;
        check_eq("abort_btn", btn_out, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        for (int k = 0; k < 3; k++) begin
          tick();
          check_eq("abort_nodone", done, 0);
          check_eq("abort_idle", busy, 0);
        end
        return;
      end
      if (c <= total) begin
        st = (c - 1) / P;
        ph = (c - 1) % P;
        if (ph < H) check_btn("btn_hold", tbl_m[st], 1'b1, ph);
        else        check_btn("btn_gap", tbl_m[st], 1'b0, ph - H);
        check_eq("busy_run", busy, 1);
        check_eq("done_run", done, 0);
        check_eq("step_idx", step_idx, st);
      end else if (c == total + 1) begin
        check_eq("done_pulse", done, 1);
        check_eq("busy_end", busy, 0);
        check_eq("btn_end", btn_out, 0);
      end else begin
        check_eq("done_once", done, 0);
        check_eq("busy_after", busy, 0);
      end
      start       = inject && (c == 3);
      cfg_we      = inject && (c == 3);
      cfg_addr    = 3'd1;
      cfg_pattern = 3'b011;
      abort       = (abort_at == c);
      tick();
    end
    start  = 1'b0;
    cfg_we = 1'b0;
    abort  = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    cfg_we      = 1'b0;
    cfg_addr    = '0;
    cfg_pattern = '0;
    num_steps   = '0;
    start       = 1'b0;
    abort       = 1'b0;
    #12;
    check_eq("rst_btn", btn_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_idx", step_idx, 0);
    rst_n = 1'b1;
    tick();

    // Basic two-step run: 001 then 110, done at cycle 13
    wr(0, 3'b001);
    wr(1, 3'b110);
    run_seq(2, 2, 1'b0, 0);

    // Zero steps: done at cycle 1, no busy
    run_seq(0, 0, 1'b0, 0);

    // start and table write while busy are ignored
    run_seq(2, 2, 1'b1, 0);

    // Clamp 15 -> 8 steps, including a 000 step at entry 0
    for (int i = 0; i < DEPTH; i++) wr(i, 3'(i * 3));
    run_seq(15, 8, 1'b0, 0);

    // Abort at cycle 6, then a fresh start runs to completion
    wr(0, 3'b001);
    wr(1, 3'b110);
    run_seq(2, 2, 1'b0, 6);
    run_seq(2, 2, 1'b0, 0);

    // abort and start together in IDLE: start dropped
    num_steps = 4'd2;
    start     = 1'b1;
    abort     = 1'b1;
    tick();
    start     = 1'b0;
    abort     = 1'b0;
    check_eq("abst_busy", busy, 0);
    check_eq("abst_btn", btn_out, 0);
    tick();
    check_eq("abst_busy2", busy, 0);
    check_eq("abst_done", done, 0);

`ifdef BUTTON_SEQ_BOUNCE_EN
    wr(0, 3'b111);
    run_seq(1, 1, 1'b0, 0);
    wr(0, 3'b001);
`endif

    // Asynchronous reset mid-play (during step 1)
    num_steps = 4'd2;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check_eq("pre_rst_idx", step_idx, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_btn", btn_out, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_idx", step_idx, 0);
    #2;
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
